// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and sequencer in front of the single-port data memory.
// Each access takes IDLE -> ACCESS -> RESP; out-of-window addresses get an error ack and no memory access.
module dmem_arbiter #(
    parameter int          DATA_WIDTH = 32,
    parameter int          ADDR_WIDTH = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h2400
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [31:0]           a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_gnt,
    output logic                  a_ack,
    output logic                  a_err,
    output logic [DATA_WIDTH-1:0] a_rdata,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [31:0]           b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_gnt,
    output logic                  b_ack,
    output logic                  b_err,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic [31:0]           mem_addr,
    output logic                  mem_rw_rd,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout
);

    // Handshake: a requester holds req and its command stable until a one-cycle gnt;
    // exactly one ack (qualified by err, with rdata) follows two cycles after gnt.
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [32:0] WIN_LAST = {1'b0, BASE_ADDR} + (33'd1 << ADDR_WIDTH) - 33'd1;

    state_t                state;
    logic                  last_grant_b;
    logic                  cur_b;
    logic                  cur_we;
    logic                  oor;

    logic                  pick_b;
    logic                  sel_we;
    logic [31:0]           sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  sel_ok;
    logic [DATA_WIDTH-1:0] resp_data;

    always_comb begin
        pick_b    = b_req && (!a_req || !last_grant_b);
        sel_we    = pick_b ? b_we    : a_we;
        sel_addr  = pick_b ? b_addr  : a_addr;
        sel_wdata = pick_b ? b_wdata : a_wdata;
        // No wrap: the upper bound is compared in 33 bits.
        sel_ok    = (sel_addr >= BASE_ADDR) && ({1'b0, sel_addr} <= WIN_LAST);
        resp_data = (cur_we || oor) ? '0 : mem_dout;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state        <= IDLE;
            last_grant_b <= 1'b1;
            cur_b        <= 1'b0;
            cur_we       <= 1'b0;
            oor          <= 1'b0;
            a_gnt        <= 1'b0;
            a_ack        <= 1'b0;
            a_err        <= 1'b0;
            a_rdata      <= '0;
            b_gnt        <= 1'b0;
            b_ack        <= 1'b0;
            b_err        <= 1'b0;
            b_rdata      <= '0;
            mem_addr     <= BASE_ADDR;
            mem_rw_rd    <= 1'b1;
            mem_din      <= '0;
        end else begin
            a_gnt <= 1'b0;
            b_gnt <= 1'b0;
            a_ack <= 1'b0;
            b_ack <= 1'b0;
            a_err <= 1'b0;
            b_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (a_req || b_req) begin
                        cur_b        <= pick_b;
                        last_grant_b <= pick_b;
                        cur_we       <= sel_we;
                        oor          <= !sel_ok;
                        a_gnt        <= !pick_b;
                        b_gnt        <= pick_b;
                        if (sel_ok) begin
                            mem_addr  <= sel_addr;
                            mem_rw_rd <= ~sel_we;
                            mem_din   <= sel_wdata;
                        end else begin
                            mem_addr  <= BASE_ADDR;
                            mem_rw_rd <= 1'b1;
                        end
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    mem_rw_rd <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (cur_b) begin
                        b_ack   <= 1'b1;
                        b_err   <= oor;
                        b_rdata <= resp_data;
                    end else begin
                        a_ack   <= 1'b1;
                        a_err   <= oor;
                        a_rdata <= resp_data;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a word-addressed memory model behind it.
// Inputs change and outputs are sampled on the falling edge.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        a_req, a_we, b_req, b_we;
    logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
    logic        a_gnt, a_ack, a_err, b_gnt, b_ack, b_err;
    logic [31:0] a_rdata, b_rdata;
    logic [31:0] mem_addr, mem_din, mem_dout;
    logic        mem_rw_rd;

    logic [31:0] mem [0:1023];
    logic        preload;
    logic [31:0] exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    dmem_arbiter dut (
        .CLK(clk), .RST_N(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_ack(a_ack), .a_err(a_err), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_ack(b_ack), .b_err(b_err), .b_rdata(b_rdata),
        .mem_addr(mem_addr), .mem_rw_rd(mem_rw_rd), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memory model: registered read, write when RW_RD=0
    always @(posedge clk) begin
        logic [31:0] off;
        off = mem_addr - 32'h2400;
        if (preload) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
            mem[0]     <= 32'd7;
            mem[2]     <= 32'd2001;
            mem[3]     <= 32'd4001;
            mem[4]     <= 32'd5001;
            mem[5]     <= 32'd3001;
            mem[10'h3FF] <= 32'h1234;
        end else begin
            if (!mem_rw_rd) mem[off[9:0]] <= mem_din;
            mem_dout <= mem[off[9:0]];
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // driver: one complete access on one port, checked against the scoreboard
    task automatic access(input string tag, input logic port, input logic we,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err,
                          input logic exp_rw, input logic [31:0] exp_maddr);
        logic        got;
        logic [31:0] want;
        exp_q.push_back(exp_rdata);
        if (port) begin b_req = 1; b_we = we; b_addr = addr; b_wdata = wdata; end
        else      begin a_req = 1; a_we = we; a_addr = addr; a_wdata = wdata; end
        got = 0;
        for (int i = 0; i < 8 && !got; i++) begin
            tick();
            got = port ? b_gnt : a_gnt;
        end
        check({tag, " gnt"}, {31'b0, got}, 32'd1);
        check({tag, " rw_rd c1"}, {31'b0, mem_rw_rd}, {31'b0, exp_rw});
        check({tag, " mem_addr c1"}, mem_addr, exp_maddr);
        if (port) b_req = 0; else a_req = 0;
        tick();
        check({tag, " ack c2"}, {31'b0, port ? b_ack : a_ack}, 32'd0);
        check({tag, " rw_rd c2"}, {31'b0, mem_rw_rd}, 32'd1);
        tick();
        want = exp_q.pop_front();
        check({tag, " ack c3"}, {31'b0, port ? b_ack : a_ack}, 32'd1);
        check({tag, " err c3"}, {31'b0, port ? b_err : a_err}, {31'b0, exp_err});
        check({tag, " rdata c3"}, port ? b_rdata : a_rdata, want);
        check({tag, " rw_rd c3"}, {31'b0, mem_rw_rd}, 32'd1);
    endtask

    initial begin
        rst_n = 0; preload = 1;
        a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
        b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
        tick(); tick();
        preload = 0;
        tick();

        // reset values
        check("rst a_gnt", {31'b0, a_gnt}, 32'd0);
        check("rst b_ack", {31'b0, b_ack}, 32'd0);
        check("rst a_err", {31'b0, a_err}, 32'd0);
        check("rst a_rdata", a_rdata, 32'd0);
        check("rst b_rdata", b_rdata, 32'd0);
        check("rst mem_addr", mem_addr, 32'h2400);
        check("rst rw_rd", {31'b0, mem_rw_rd}, 32'd1);
        check("rst mem_din", mem_din, 32'd0);

        // simultaneous requests at first idle edge: A first, then B, then A again
        rst_n = 1;
        a_req = 1; a_we = 0; a_addr = 32'h2402;
        b_req = 1; b_we = 0; b_addr = 32'h2403;
        tick();
        check("sim1 a_gnt", {31'b0, a_gnt}, 32'd1);
        check("sim1 b_gnt", {31'b0, b_gnt}, 32'd0);
        a_req = 0;
        tick();
        check("sim1 a_ack c2", {31'b0, a_ack}, 32'd0);
        tick();
        check("sim1 a_ack", {31'b0, a_ack}, 32'd1);
        check("sim1 a_rdata", a_rdata, 32'd2001);
        check("sim1 b_gnt c3", {31'b0, b_gnt}, 32'd0);
        tick();
        check("sim2 b_gnt", {31'b0, b_gnt}, 32'd1);
        b_req = 0;
        tick(); tick();
        check("sim2 b_ack", {31'b0, b_ack}, 32'd1);
        check("sim2 b_rdata", b_rdata, 32'd4001);
        a_req = 1; a_addr = 32'h2404;
        b_req = 1; b_addr = 32'h2405;
        tick();
        check("sim3 a_gnt", {31'b0, a_gnt}, 32'd1);
        check("sim3 b_gnt", {31'b0, b_gnt}, 32'd0);
        a_req = 0;
        tick(); tick();
        check("sim3 a_rdata", a_rdata, 32'd5001);
        tick();
        check("sim4 b_gnt", {31'b0, b_gnt}, 32'd1);
        b_req = 0;
        tick(); tick();
        check("sim4 b_ack", {31'b0, b_ack}, 32'd1);
        check("sim4 b_rdata", b_rdata, 32'd3001);

        // plain read, write then readback on B
        access("rd a", 1'b0, 1'b0, 32'h2402, 32'h0, 32'd2001, 1'b0, 1'b1, 32'h2402);
        access("wr b", 1'b1, 1'b1, 32'h2410, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 32'h2410);
        access("rdbk b", 1'b1, 1'b0, 32'h2410, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1, 32'h2410);

        // window boundaries
        access("oor wr", 1'b0, 1'b1, 32'h23FF, 32'h00000BAD, 32'h0, 1'b1, 1'b1, 32'h2400);
        access("oor rd", 1'b1, 1'b0, 32'h2800, 32'h0, 32'h0, 1'b1, 1'b1, 32'h2400);
        access("base rd", 1'b0, 1'b0, 32'h2400, 32'h0, 32'd7, 1'b0, 1'b1, 32'h2400);
        access("top rd", 1'b1, 1'b0, 32'h27FF, 32'h0, 32'h1234, 1'b0, 1'b1, 32'h27FF);

        // back-to-back reads with a_req held
        a_req = 1; a_we = 0; a_addr = 32'h2402;
        for (int i = 0; i < 4; i++) begin
            logic [31:0] exp_vals [4];
            exp_vals = '{32'd2001, 32'd4001, 32'd5001, 32'd3001};
            tick();
            check($sformatf("b2b%0d gnt", i), {31'b0, a_gnt}, 32'd1);
            if (i == 3) a_req = 0;
            else a_addr = 32'h2403 + i;
            tick();
            check($sformatf("b2b%0d gnt c2", i), {31'b0, a_gnt}, 32'd0);
            tick();
            check($sformatf("b2b%0d ack", i), {31'b0, a_ack}, 32'd1);
            check($sformatf("b2b%0d rdata", i), a_rdata, exp_vals[i]);
        end

        // reset during the ACCESS cycle of a read
        a_req = 1; a_we = 0; a_addr = 32'h2403;
        tick();
        check("mid gnt", {31'b0, a_gnt}, 32'd1);
        a_req = 0; rst_n = 0;
        tick();
        check("mid gnt clr", {31'b0, a_gnt}, 32'd0);
        check("mid rdata", a_rdata, 32'd0);
        check("mid mem_addr", mem_addr, 32'h2400);
        check("mid rw_rd", {31'b0, mem_rw_rd}, 32'd1);
        rst_n = 1;
        tick();
        check("mid no ack", {31'b0, a_ack}, 32'd0);
        tick();
        check("mid no ack2", {31'b0, a_ack}, 32'd0);
        access("post rst", 1'b0, 1'b0, 32'h2404, 32'h0, 32'd5001, 1'b0, 1'b1, 32'h2404);

        // final report
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
